hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, meaning total cycles a multicycle op occupies E; legal range 2..16.
REQ-002 SHALL have clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have RsD, RtD  in  5 each  D-stage source register numbers.
REQ-005 SHALL have RsE, RtE  in  5 each  E-stage source register numbers.
REQ-006 SHALL have WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
REQ-007 SHALL have RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes register file.
REQ-008 SHALL have MemtoRegE, MemtoRegM  in  1 each  stage holds a load.
REQ-009 SHALL have BranchD  in  1  branch resolved in D this cycle.
REQ-010 SHALL have MulDivStartE  in  1  multicycle mul/div op present in E.
REQ-011 SHALL have ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 RF read, 01 W-stage result, 10 ALUOutM; 11 never driven.
REQ-012 SHALL have ForwardAD, ForwardBD  out  1 each  D-stage branch comparator takes ALUOutM.
REQ-013 SHALL have StallF, StallD, StallE  out  1 each  hold stage register.
REQ-014 SHALL have FlushE, FlushM  out  1 each  insert bubble into E / M.
REQ-015 SHALL have MulDivBusy  out  1  multicycle sequencer active.

Function
REQ-016 Register 0 SHALL never match for forwarding or stall purposes.
REQ-017 ForwardAE SHALL be 10 if RegWriteM and WriteRegM==RsE; else 01 if RegWriteW and WriteRegW==RsE; else 00 (M priority over W); ForwardBE identical with RtE.
REQ-018 ForwardAD SHALL be RegWriteM and WriteRegM==RsD; ForwardBD same with RtD; no W-stage forwarding to D.
REQ-019 lwstall SHALL be MemtoRegE and RegWriteE and WriteRegE equal to RsD or RtD.
REQ-020 brstall SHALL be BranchD and ((RegWriteE and WriteRegE equal to RsD or RtD) or (MemtoRegM and WriteRegM equal to RsD or RtD)).
REQ-021 Sequencer FSM SHALL have states IDLE and BUSY plus 4-bit down-counter cnt.
REQ-022 IDLE with MulDivStartE SHALL go to BUSY, load cnt=MULDIV_CYCLES-2; mdstall asserted that same cycle.
REQ-023 BUSY with cnt!=0 SHALL assert mdstall, decrement cnt; BUSY with cnt==0 SHALL deassert mdstall, return to IDLE next edge.
REQ-024 MulDivStartE sampled in BUSY SHALL be ignored (same op still in E).
REQ-025 MulDivBusy SHALL be high when state==BUSY or mdstall.
REQ-026 StallF = StallD = lwstall or brstall or mdstall; StallE = mdstall.
REQ-027 FlushE SHALL be (lwstall or brstall) and not mdstall; FlushM SHALL equal mdstall.
REQ-028 All forward/stall/flush outputs SHALL be combinational from inputs and current state (zero latency).

Reset
REQ-029 rst high at an edge SHALL set state IDLE, cnt 0, regardless of BUSY progress.
REQ-030 While rst is high all outputs SHALL be 0.
REQ-031 Operation SHALL resume on first edge after rst falls; reset mid-BUSY abandons the op with no further stall.

Verification
REQ-032 RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5, RtE=0 -> ForwardAE=10, ForwardBE=00.
REQ-033 MemtoRegE=RegWriteE=1, WriteRegE=7, RtD=7 -> StallF=StallD=FlushE=1 one cycle; WriteRegE=0 with RsD=0 -> no stall.
REQ-034 BranchD=1, RsD=3, MemtoRegM=1, WriteRegM=3 -> StallF=StallD=FlushE=1, ForwardAD=1.
REQ-035 MULDIV_CYCLES=4, MulDivStartE held from cycle t -> StallF/D/E and FlushM high cycles t..t+2, low at t+3; MulDivBusy high t..t+3; IDLE at t+4.
REQ-036 lwstall coincident with mdstall -> FlushE=0, FlushM=1; rst asserted at t+1 of a busy op -> all outputs 0, IDLE after edge.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding, load/branch interlocks and a mul/div occupancy sequencer.
// Forward/stall/flush outputs are zero-latency from inputs and sequencer state; all outputs held low during reset.
module hazard_unit #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MulDivStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulDivBusy
);

  typedef enum logic {IDLE, BUSY} state_t;

  // The start cycle itself is one of the stalled cycles, hence the -2.
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mdstall_raw;

  logic       valid_e, valid_m, valid_w;
  logic       m_rs_e, m_rt_e, w_rs_e, w_rt_e;
  logic       m_rs_d, m_rt_d, e_rs_d, e_rt_d;
  logic       lwstall, brstall, mdstall, stall_fd;
  logic [1:0] fwd_a_e, fwd_b_e;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign valid_e = (WriteRegE != 5'd0);
  assign valid_m = (WriteRegM != 5'd0);
  assign valid_w = (WriteRegW != 5'd0);

  assign m_rs_e = RegWriteM & valid_m & (WriteRegM == RsE);
  assign m_rt_e = RegWriteM & valid_m & (WriteRegM == RtE);
  assign w_rs_e = RegWriteW & valid_w & (WriteRegW == RsE);
  assign w_rt_e = RegWriteW & valid_w & (WriteRegW == RtE);

  assign m_rs_d = valid_m & (WriteRegM == RsD);
  assign m_rt_d = valid_m & (WriteRegM == RtD);
  assign e_rs_d = valid_e & (WriteRegE == RsD);
  assign e_rt_d = valid_e & (WriteRegE == RtD);

  assign fwd_a_e = m_rs_e ? 2'b10 : (w_rs_e ? 2'b01 : 2'b00);
  assign fwd_b_e = m_rt_e ? 2'b10 : (w_rt_e ? 2'b01 : 2'b00);

  assign lwstall = MemtoRegE & RegWriteE & (e_rs_d | e_rt_d);
  assign brstall = BranchD & ((RegWriteE & (e_rs_d | e_rt_d)) |
                              (MemtoRegM & (m_rs_d | m_rt_d)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start seen while BUSY belongs to the op already being sequenced.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mdstall_raw = 1'b0;
    case (state)
      IDLE: begin
        if (MulDivStartE) begin
          state_nxt   = BUSY;
          cnt_nxt     = CNT_LOAD;
          mdstall_raw = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          mdstall_raw = 1'b1;
          cnt_nxt     = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mdstall  = mdstall_raw & ~rst;
  assign stall_fd = lwstall | brstall | mdstall;

  assign ForwardAE  = rst ? 2'b00 : fwd_a_e;
  assign ForwardBE  = rst ? 2'b00 : fwd_b_e;
  assign ForwardAD  = ~rst & RegWriteM & m_rs_d;
  assign ForwardBD  = ~rst & RegWriteM & m_rt_d;
  assign StallF     = ~rst & stall_fd;
  assign StallD     = ~rst & stall_fd;
  assign StallE     = mdstall;
  assign FlushE     = ~rst & (lwstall | brstall) & ~mdstall;
  assign FlushM     = mdstall;
  assign MulDivBusy = ~rst & ((state == BUSY) | mdstall);

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus randomized cycles against an occupancy-count model.
module tb_hazard_unit;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MulDivStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, FlushM, MulDivBusy;

  int checks = 0;
  int errors = 0;
  // Cycles the current mul/div op still occupies E, counting the present cycle.
  int occ = 0;

  logic [11:0] obs;
  assign obs = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, FlushM, MulDivBusy};

  hazard_unit #(.MULDIV_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MulDivStartE(MulDivStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
    .MulDivBusy(MulDivBusy)
  );

  function automatic int eff_occ();
    return (occ == 0 && MulDivStartE) ? N : occ;
  endfunction

  function automatic logic [11:0] model_out();
    logic [1:0] fa, fb;
    logic fad, fbd, lw, br, md, busy;
    logic e_hit, m_hit;
    int e;
    if (rst) return 12'd0;
    fa = (RegWriteM && WriteRegM != 0 && WriteRegM == RsE) ? 2'd2 :
         (RegWriteW && WriteRegW != 0 && WriteRegW == RsE) ? 2'd1 : 2'd0;
    fb = (RegWriteM && WriteRegM != 0 && WriteRegM == RtE) ? 2'd2 :
         (RegWriteW && WriteRegW != 0 && WriteRegW == RtE) ? 2'd1 : 2'd0;
    fad = RegWriteM && WriteRegM != 0 && WriteRegM == RsD;
    fbd = RegWriteM && WriteRegM != 0 && WriteRegM == RtD;
    e_hit = WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    m_hit = WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD);
    lw = MemtoRegE && RegWriteE && e_hit;
    br = BranchD && ((RegWriteE && e_hit) || (MemtoRegM && m_hit));
    e = eff_occ();
    md = (e > 1);
    busy = (e > 0);
    return {fa, fb, fad, fbd, lw | br | md, lw | br | md, md, (lw | br) & ~md, md, busy};
  endfunction

  task automatic tick();
    int nxt;
    nxt = rst ? 0 : ((eff_occ() > 0) ? eff_occ() - 1 : 0);
    @(posedge clk);
    occ = nxt;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; MulDivStartE = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    RsD = 5; RtD = 5; RsE = 5; RtE = 5; WriteRegE = 5; WriteRegM = 5; WriteRegW = 5;
    RegWriteE = 1; RegWriteM = 1; RegWriteW = 1; MemtoRegE = 1; MemtoRegM = 1;
    BranchD = 1; MulDivStartE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== 12'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b expected %b", i, obs, 12'd0);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (obs !== 12'd0) begin
      errors++;
      $display("FAIL post_reset_idle got %b expected %b", obs, 12'd0);
    end
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b10_00) begin
      errors++;
      $display("FAIL fwd_m_priority got AE=%b BE=%b expected AE=10 BE=00", ForwardAE, ForwardBE);
    end
    RegWriteM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++;
      $display("FAIL fwd_w_only got %b expected 01", ForwardAE);
    end
    RegWriteM = 1; WriteRegM = 0; RegWriteW = 0; RsE = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_reg0 got %b expected 00", ForwardAE);
    end
    WriteRegM = 9; RsD = 9; RtD = 2; RegWriteW = 1; WriteRegW = 2;
    #1;
    checks++;
    if ({ForwardAD, ForwardBD} !== 2'b10) begin
      errors++;
      $display("FAIL fwd_d got AD=%b BD=%b expected AD=1 BD=0", ForwardAD, ForwardBD);
    end
    tick();
  endtask

  task automatic test_lwstall();
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RtD = 7; RsD = 1;
    #1;
    checks++;
    if ({StallF, StallD, StallE, FlushE, FlushM} !== 5'b11010) begin
      errors++;
      $display("FAIL lwstall got F/D/E/FE/FM=%b expected 11010", {StallF, StallD, StallE, FlushE, FlushM});
    end
    tick();
    MemtoRegE = 0; RegWriteE = 0;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++;
      $display("FAIL lwstall_release got %b expected 000", {StallF, StallD, FlushE});
    end
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 0; RsD = 0; RtD = 0;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++;
      $display("FAIL lwstall_reg0 got %b expected 000", {StallF, StallD, FlushE});
    end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchD = 1; RsD = 3; RtD = 4; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 3;
    #1;
    checks++;
    if ({StallF, StallD, FlushE, ForwardAD} !== 4'b1111) begin
      errors++;
      $display("FAIL brstall_load got F/D/FE/AD=%b expected 1111", {StallF, StallD, FlushE, ForwardAD});
    end
    MemtoRegM = 0; RegWriteE = 1; WriteRegE = 4; WriteRegM = 8;
    #1;
    checks++;
    if ({StallF, FlushE, ForwardAD} !== 3'b110) begin
      errors++;
      $display("FAIL brstall_alu got F/FE/AD=%b expected 110", {StallF, FlushE, ForwardAD});
    end
    BranchD = 0;
    #1;
    checks++;
    if ({StallF, FlushE} !== 2'b00) begin
      errors++;
      $display("FAIL no_branch got %b expected 00", {StallF, FlushE});
    end
    tick();
  endtask

  task automatic test_muldiv();
    logic st_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic bz_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      MulDivStartE = (k < 4);
      #1;
      checks++;
      if ({StallF, StallD, StallE, FlushM, MulDivBusy} !== {{4{st_exp[k]}}, bz_exp[k]}) begin
        errors++;
        $display("FAIL muldiv t+%0d got F/D/E/FM/busy=%b expected %b", k,
                 {StallF, StallD, StallE, FlushM, MulDivBusy}, {{4{st_exp[k]}}, bz_exp[k]});
      end
      tick();
    end
  endtask

  task automatic test_collision_reset();
    clear_inputs();
    MulDivStartE = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RtD = 7;
    #1;
    checks++;
    if ({StallF, StallE, FlushE, FlushM} !== 4'b1101) begin
      errors++;
      $display("FAIL lw_md_collision got F/E/FE/FM=%b expected 1101", {StallF, StallE, FlushE, FlushM});
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_busy got %b expected %b", obs, 12'd0);
    end
    tick();
    rst = 1'b0;
    MulDivStartE = 0;
    #1;
    checks++;
    if ({StallE, FlushM, MulDivBusy, FlushE} !== 4'b0001) begin
      errors++;
      $display("FAIL after_reset_abandon got E/FM/busy/FE=%b expected 0001", {StallE, FlushM, MulDivBusy, FlushE});
    end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] exp;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom); BranchD = 1'($urandom);
      MulDivStartE = ($urandom_range(0, 5) == 0);
      #1;
      exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random cycle %0d got %b expected %b", i, obs, exp);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_lwstall();
    test_branch();
    test_muldiv();
    test_collision_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
